// File: rtl/mem_stage_access.sv
// +----------------------------------------------------------------------------+
// | Module : mem_stage_access                                                  |
// | MEM-stage data-memory handshake, front-end stall and MEM/WB register.      |
// | Optional feature macro: MISALIGN_TRAP_EN (adds misalign trap output).      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_stage_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_w_signal_mem,
  input  logic        write_mem,
  input  logic        is_lw_mem,
  input  logic        is_jal_mem,
  input  logic        is_mul_mem,
  input  logic [4:0]  w_addr_mem,
  input  logic [31:0] alu_mem,
  input  logic [31:0] mul_mem,
  input  logic [31:0] npc_mem,
  input  logic [31:0] dm_wdata_mem,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        bus_err,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        write_wb,
  output logic [4:0]  w_addr_wb,
  output logic [31:0] wb_data_wb
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_bus_err;
  logic        r_misal;
  logic        w_mem_op;
  logic        w_timeout;
  logic        w_misal;
  logic [31:0] w_req_addr;
  logic [31:0] w_wb_data;
  logic        w_wb_we;

  assign w_mem_op  = is_lw_mem | dm_w_signal_mem;
  assign w_timeout = (r_state == c_WAIT) && (r_cnt == c_TMO_LAST);

`ifdef MISALIGN_TRAP_EN
  assign w_misal    = w_mem_op & (alu_mem[1:0] != 2'b00);
  assign w_req_addr = alu_mem;
  assign misalign   = r_misal;
`else
  assign w_misal    = 1'b0;
  assign w_req_addr = {alu_mem[31:2], 2'b00};
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: if (w_mem_op) w_state_nxt = w_misal ? c_DONE : c_WAIT;
      c_WAIT: if (dm_ack || w_timeout) w_state_nxt = c_DONE;
      c_DONE: w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_cnt     <= 8'd0;
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
      r_bus_err <= 1'b0;
      r_misal   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bus_err <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_mem_op) begin
            r_we    <= dm_w_signal_mem;
            r_addr  <= w_req_addr;
            r_wdata <= dm_wdata_mem;
            r_rdata <= 32'd0;
            r_cnt   <= 8'd0;
            r_misal <= w_misal;
          end
        end
        c_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          // A coincident ack beats the timeout.
          if (dm_ack) begin
            r_rdata <= dm_rdata;
          end else if (w_timeout) begin
            r_rdata   <= 32'd0;
            r_bus_err <= 1'b1;
          end
        end
        c_DONE: begin
          r_cnt   <= 8'd0;
          r_misal <= 1'b0;
        end
        default: r_cnt <= 8'd0;
      endcase
    end
  end

  assign dm_req   = (r_state == c_WAIT);
  assign dm_we    = dm_req & r_we;
  assign dm_addr  = r_addr;
  assign dm_wdata = r_wdata;
  assign bus_err  = r_bus_err;

  // Gated by rst so the pipeline unfreezes the instant reset is applied.
  assign stall = ~rst & (((r_state == c_IDLE) & w_mem_op) | (r_state == c_WAIT));

  assign w_wb_data = is_lw_mem  ? r_rdata :
                     is_jal_mem ? npc_mem :
                     is_mul_mem ? mul_mem : alu_mem;
  assign w_wb_we   = write_mem & ~dm_w_signal_mem & ~r_misal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_wb   <= 1'b0;
      w_addr_wb  <= 5'd0;
      wb_data_wb <= 32'd0;
    end else if (stall) begin
      write_wb   <= 1'b0;
      w_addr_wb  <= 5'd0;
      wb_data_wb <= 32'd0;
    end else begin
      write_wb   <= w_wb_we;
      w_addr_wb  <= w_addr_mem;
      wb_data_wb <= w_wb_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_access.sv
// +----------------------------------------------------------------------------+
// | Module : tb_mem_stage_access                                               |
// | Directed self-checking bench for mem_stage_access (TIMEOUT_CYCLES = 4).    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_stage_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        dm_w_signal_mem, write_mem, is_lw_mem, is_jal_mem, is_mul_mem;
  logic [4:0]  w_addr_mem;
  logic [31:0] alu_mem, mul_mem, npc_mem, dm_wdata_mem;
  logic        dm_req, dm_we, dm_ack, stall, bus_err, write_wb;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, wb_data_wb;
  logic [4:0]  w_addr_wb;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr, exp_wdata, ack_data;
  logic        exp_we;

  mem_stage_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .dm_w_signal_mem(dm_w_signal_mem), .write_mem(write_mem),
    .is_lw_mem(is_lw_mem), .is_jal_mem(is_jal_mem), .is_mul_mem(is_mul_mem),
    .w_addr_mem(w_addr_mem), .alu_mem(alu_mem), .mul_mem(mul_mem),
    .npc_mem(npc_mem), .dm_wdata_mem(dm_wdata_mem),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall), .bus_err(bus_err),
    .write_wb(write_wb), .w_addr_wb(w_addr_wb), .wb_data_wb(wb_data_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic lw, input logic sw, input logic wr, input logic jal,
                        input logic mul, input logic [4:0] wa, input logic [31:0] alu,
                        input logic [31:0] mr, input logic [31:0] npc, input logic [31:0] wd);
    is_lw_mem = lw; dm_w_signal_mem = sw; write_mem = wr; is_jal_mem = jal;
    is_mul_mem = mul; w_addr_mem = wa; alu_mem = alu; mul_mem = mr;
    npc_mem = npc; dm_wdata_mem = wd;
  endtask

  // Called at posedge+1 with the op already driven; returns at posedge+1
  // just after the MEM/WB register has captured the op's result.
  task automatic run_op(input int ack_at, output int req_n, output int stall_n,
                        output int err_n, output int bad, output int done);
    req_n = 0; stall_n = 0; err_n = 0; bad = 0; done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_err) err_n++;
      if (!stall) begin
        done = 1;
        break;
      end
      if (stall_n >= 1 && (write_wb !== 1'b0 || w_addr_wb !== 5'd0 || wb_data_wb !== 32'd0))
        bad++;
      stall_n++;
      if (dm_req) begin
        req_n++;
        if (dm_addr !== exp_addr || dm_we !== exp_we || (exp_we && dm_wdata !== exp_wdata))
          bad++;
        if (req_n == ack_at) begin
          dm_ack   = 1'b1;
          dm_rdata = ack_data;
        end
      end
      @(posedge clk); #1;
      dm_ack   = 1'b0;
      dm_rdata = 32'hA5A5_A5A5;
    end
    @(posedge clk); #1;
  endtask

  int rq, st, er, bd, dn;

  initial begin
    rst = 1'b1; dm_ack = 1'b0; dm_rdata = 32'h0;
    exp_addr = 0; exp_wdata = 0; exp_we = 0; ack_data = 0;
    set_in(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_write_wb", 32'(write_wb), 32'd0);
    chk("rst_w_addr_wb", 32'(w_addr_wb), 32'd0);
    chk("rst_wb_data", wb_data_wb, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ALU op
    set_in(0, 0, 1, 0, 0, 5'd8, 32'h42, 32'h0, 32'h0, 32'h0);
    run_op(0, rq, st, er, bd, dn);
    chk("alu_done", 32'(dn), 32'd1);
    chk("alu_stall", 32'(st), 32'd0);
    chk("alu_write_wb", 32'(write_wb), 32'd1);
    chk("alu_w_addr", 32'(w_addr_wb), 32'd8);
    chk("alu_data", wb_data_wb, 32'h42);

    // mul op
    set_in(0, 0, 1, 0, 1, 5'd3, 32'h11, 32'h777, 32'h0, 32'h0);
    run_op(0, rq, st, er, bd, dn);
    chk("mul_data", wb_data_wb, 32'h777);
    chk("mul_w_addr", 32'(w_addr_wb), 32'd3);

    // lw, ack on 3rd request cycle
    set_in(1, 0, 1, 0, 0, 5'd9, 32'h100, 32'h0, 32'h0, 32'h0);
    exp_addr = 32'h100; exp_we = 0; ack_data = 32'hDEAD_BEEF;
    run_op(3, rq, st, er, bd, dn);
    chk("lw_done", 32'(dn), 32'd1);
    chk("lw_req_cycles", 32'(rq), 32'd3);
    chk("lw_stall_cycles", 32'(st), 32'd4);
    chk("lw_bus_fields_bubble", 32'(bd), 32'd0);
    chk("lw_data", wb_data_wb, 32'hDEAD_BEEF);
    chk("lw_write_wb", 32'(write_wb), 32'd1);
    chk("lw_w_addr", 32'(w_addr_wb), 32'd9);
    chk("lw_no_err", 32'(er), 32'd0);

    // sw, ack after 1 cycle
    set_in(0, 1, 1, 0, 0, 5'd4, 32'h200, 32'h0, 32'h0, 32'h1234_5678);
    exp_addr = 32'h200; exp_we = 1; exp_wdata = 32'h1234_5678; ack_data = 32'h0;
    run_op(1, rq, st, er, bd, dn);
    chk("sw_req_cycles", 32'(rq), 32'd1);
    chk("sw_stall_cycles", 32'(st), 32'd2);
    chk("sw_bus_fields", 32'(bd), 32'd0);
    chk("sw_write_wb", 32'(write_wb), 32'd0);

    // lw timeout (no ack)
    set_in(1, 0, 1, 0, 0, 5'd10, 32'h300, 32'h0, 32'h0, 32'h0);
    exp_addr = 32'h300; exp_we = 0; ack_data = 32'h0;
    run_op(0, rq, st, er, bd, dn);
    chk("tmo_done", 32'(dn), 32'd1);
    chk("tmo_req_cycles", 32'(rq), 32'd4);
    chk("tmo_stall_cycles", 32'(st), 32'd5);
    chk("tmo_bus_err_pulses", 32'(er), 32'd1);
    chk("tmo_data", wb_data_wb, 32'd0);
    chk("tmo_bus_err_cleared", 32'(bus_err), 32'd0);

    // lw with ack on the timeout cycle: ack wins
    set_in(1, 0, 1, 0, 0, 5'd11, 32'h304, 32'h0, 32'h0, 32'h0);
    exp_addr = 32'h304; ack_data = 32'hCAFE_F00D;
    run_op(4, rq, st, er, bd, dn);
    chk("late_ack_req_cycles", 32'(rq), 32'd4);
    chk("late_ack_bus_err", 32'(er), 32'd0);
    chk("late_ack_data", wb_data_wb, 32'hCAFE_F00D);

    // misaligned lw: low address bits forced to zero
    set_in(1, 0, 1, 0, 0, 5'd12, 32'h103, 32'h0, 32'h0, 32'h0);
    exp_addr = 32'h100; ack_data = 32'h0BAD_CAFE;
    run_op(2, rq, st, er, bd, dn);
    chk("misal_addr_fields", 32'(bd), 32'd0);
    chk("misal_data", wb_data_wb, 32'h0BAD_CAFE);

    // jal then lw back-to-back
    set_in(0, 0, 1, 1, 0, 5'd31, 32'h0, 32'h0, 32'h0040_0010, 32'h0);
    run_op(0, rq, st, er, bd, dn);
    chk("jal_stall", 32'(st), 32'd0);
    chk("jal_req", 32'(rq), 32'd0);
    chk("jal_data", wb_data_wb, 32'h0040_0010);
    chk("jal_w_addr", 32'(w_addr_wb), 32'd31);
    set_in(1, 0, 1, 0, 0, 5'd5, 32'h400, 32'h0, 32'h0, 32'h0);
    exp_addr = 32'h400; ack_data = 32'h5555_AAAA;
    run_op(2, rq, st, er, bd, dn);
    chk("jal_lw_req", 32'(rq), 32'd2);
    chk("jal_lw_data", wb_data_wb, 32'h5555_AAAA);
    set_in(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("jal_lw_no_reissue", 32'(dm_req), 32'd0);
    @(posedge clk); #1;

    // reset during WAIT
    set_in(1, 0, 1, 0, 0, 5'd6, 32'h500, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("mid_wait_req", 32'(dm_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_req", 32'(dm_req), 32'd0);
    chk("rst_async_stall", 32'(stall), 32'd0);
    chk("rst_async_write_wb", 32'(write_wb), 32'd0);
    set_in(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    dm_ack = 1'b1; dm_rdata = 32'hFFFF_0000;
    @(negedge clk);
    chk("stray_ack_req", 32'(dm_req), 32'd0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    chk("stray_ack_stall", 32'(stall), 32'd0);
    set_in(1, 0, 1, 0, 0, 5'd7, 32'h600, 32'h0, 32'h0, 32'h0);
    exp_addr = 32'h600; exp_we = 0; ack_data = 32'h1357_9BDF;
    run_op(2, rq, st, er, bd, dn);
    chk("post_rst_req", 32'(rq), 32'd2);
    chk("post_rst_stall", 32'(st), 32'd3);
    chk("post_rst_data", wb_data_wb, 32'h1357_9BDF);
    chk("post_rst_w_addr", 32'(w_addr_wb), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
